axis_byte_packer: RTL and testbench



---
 rtl/axis_byte_packer.sv | 124 ++++++++++++
 tb/tb_axis_byte_packer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_packer.sv
// axis_byte_packer: packs an 8-bit AXI-stream into WORD_BYTES-wide words
// with per-lane keep flags. s_last always closes the current word, which
// may be partial, and that word carries m_last. pkt_count counts packets
// leaving the output and wraps at 16 bits.
// Optional build macro PACK_MSB_FIRST_EN: big-endian lane order (first byte
// in the top lane, partial words left-aligned). Default is little-endian.
module axis_byte_packer #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [7:0]              s_data_i,
    input  logic                    s_valid_i,
    input  logic                    s_last_i,
    output logic                    s_ready_o,
    output logic [8*WORD_BYTES-1:0] m_data_o,
    output logic [WORD_BYTES-1:0]   m_keep_o,
    output logic                    m_valid_o,
    output logic                    m_last_o,
    input  logic                    m_ready_i,
    output logic [15:0]             pkt_count_o
);
    localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CW-1:0] LAST_POS = CW'(WORD_BYTES - 1);

    // Accumulator state: cnt_q == 0 is EMPTY, anything else is FILL.
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [8*WORD_BYTES-1:0] acc_q, acc_d;
    logic [WORD_BYTES-1:0]   acc_keep_q, acc_keep_d;
    // Output register.
    logic [8*WORD_BYTES-1:0] m_data_q, m_data_d;
    logic [WORD_BYTES-1:0]   m_keep_q, m_keep_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic [15:0]             pkt_q, pkt_d;

    logic                    s_ready;
    logic                    accept;
    logic                    complete;
    logic [CW-1:0]           lane;
    logic [8*WORD_BYTES-1:0] merged_data;
    logic [WORD_BYTES-1:0]   merged_keep;

`ifdef PACK_MSB_FIRST_EN
    assign lane = LAST_POS - cnt_q;
`else
    assign lane = cnt_q;
`endif

    // Accumulator with the incoming byte dropped into its lane.
    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
        assign merged_data[8*i +: 8] = (lane == CW'(i)) ? s_data_i : acc_q[8*i +: 8];
        assign merged_keep[i]        = (lane == CW'(i)) | acc_keep_q[i];
    end

    assign accept   = s_valid_i && s_ready;
    assign complete = (cnt_q == LAST_POS) || s_last_i;

    // State register: accumulator, output word and packet counter.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            acc_keep_q <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            pkt_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            pkt_q      <= pkt_d;
        end
    end

    // Next state: drain the output on handshake, then fold in any accepted byte.
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        pkt_d      = pkt_q;
        if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
            if (m_last_q) pkt_d = pkt_q + 16'd1;
        end
        if (accept) begin
            if (complete) begin
                // A completion overrides the drain so words can flow every cycle.
                m_data_d   = merged_data;
                m_keep_d   = merged_keep;
                m_valid_d  = 1'b1;
                m_last_d   = s_last_i;
                acc_d      = '0;
                acc_keep_d = '0;
                cnt_d      = '0;
            end else begin
                acc_d      = merged_data;
                acc_keep_d = merged_keep;
                cnt_d      = cnt_q + CW'(1);
            end
        end
    end

    // Outputs: s_ready is combinational from m_ready so a drained word frees the slot at once.
    always_comb begin
        s_ready     = reset_ni && (!m_valid_q || m_ready_i);
        s_ready_o   = s_ready;
        m_data_o    = m_data_q;
        m_keep_o    = m_keep_q;
        m_valid_o   = m_valid_q;
        m_last_o    = m_last_q;
        pkt_count_o = pkt_q;
    end
endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed bench for axis_byte_packer (WORD_BYTES=4). A byte-wise model
// pushes expected words onto a scoreboard queue as bytes are accepted; every
// output handshake pops and compares. Fixed plan values are checked too.
module tb_axis_byte_packer;
    localparam int W = 4;

    typedef struct packed {
        logic [8*W-1:0] d;
        logic [W-1:0]   k;
        logic           l;
    } word_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           s_ready;
    logic [8*W-1:0] m_data;
    logic [W-1:0]   m_keep;
    logic           m_valid;
    logic           m_last;
    logic           m_ready = 1'b1;
    logic [15:0]    pkt_count;

    axis_byte_packer #(.WORD_BYTES(W)) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_keep_o(m_keep), .m_valid_o(m_valid), .m_last_o(m_last),
        .m_ready_i(m_ready), .pkt_count_o(pkt_count)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    word_t       exp_q[$];
    word_t       got_q[$];
    logic [15:0] exp_pkt = '0;
    int          mcnt = 0;
    logic [8*W-1:0] mdata = '0;
    logic [W-1:0]   mkeep = '0;
    bit          acc_flag;
    bit          rnd_ready = 1'b0;
    int          last_wait;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-wise reference model of the packer.
    task automatic model_accept(input logic [7:0] d, input logic l);
        int ln;
`ifdef PACK_MSB_FIRST_EN
        ln = W - 1 - mcnt;
`else
        ln = mcnt;
`endif
        mdata[8*ln +: 8] = d;
        mkeep[ln] = 1'b1;
        if (mcnt == W - 1 || l) begin
            exp_q.push_back('{d: mdata, k: mkeep, l: l});
            mdata = '0; mkeep = '0; mcnt = 0;
        end else begin
            mcnt++;
        end
    endtask

    task automatic check_word();
        word_t e;
        got_q.push_back('{d: m_data, k: m_keep, l: m_last});
        if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(m_data), 64'hDEAD);
        end else begin
            e = exp_q.pop_front();
            chk("sb_data", 64'(m_data), 64'(e.d));
            chk("sb_keep", 64'(m_keep), 64'(e.k));
            chk("sb_last", 64'(m_last), 64'(e.l));
            if (m_last) exp_pkt = exp_pkt + 16'd1;
        end
    endtask

    // One clock: observe output handshake at negedge, note acceptance, step the model.
    task automatic tick();
        bit acc;
        if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (rst_n && m_valid && m_ready) check_word();
        acc = rst_n && s_valid && s_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            model_accept(s_data, s_last);
            acc_flag = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        acc_flag = 1'b0;
        while (!acc_flag && n < 100) begin
            tick();
            n++;
        end
        if (!acc_flag) chk("send_timeout", 64'(n), 64'd0);
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        last_wait = n;
    endtask

    task automatic drain();
        int n = 0;
        rnd_ready = 1'b0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("pkt_count", 64'(pkt_count), 64'(exp_pkt));
    endtask

    initial begin
        logic [8*W-1:0] hold;
        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_keep", 64'(m_keep), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_pkt", 64'(pkt_count), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready", 64'(s_ready), 64'd1);

`ifdef PACK_MSB_FIRST_EN
        got_q.delete();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), i == 4);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b1);
        drain();
        chk("msb_cnt", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("msb_w0", 64'(got_q[0].d), 64'h01020304);
            chk("msb_k0", 64'(got_q[0].k), 64'hF);
            chk("msb_w1", 64'(got_q[1].d), 64'h05060000);
            chk("msb_k1", 64'(got_q[1].k), 64'hC);
            chk("msb_l1", 64'(got_q[1].l), 64'd1);
        end
`else
        // Eight-byte packet.
        got_q.delete();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        drain();
        chk("p8_pkt", 64'(pkt_count), 64'd1);
        chk("p8_cnt", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("p8_w0", 64'(got_q[0].d), 64'h04030201);
            chk("p8_k0", 64'(got_q[0].k), 64'hF);
            chk("p8_l0", 64'(got_q[0].l), 64'd0);
            chk("p8_w1", 64'(got_q[1].d), 64'h08070605);
            chk("p8_l1", 64'(got_q[1].l), 64'd1);
        end
        // Five-byte packet ending in a partial word.
        got_q.delete();
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), i == 4);
        drain();
        chk("p5_cnt", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("p5_w0", 64'(got_q[0].d), 64'h14131211);
            chk("p5_w1", 64'(got_q[1].d), 64'h00000015);
            chk("p5_k1", 64'(got_q[1].k), 64'h1);
            chk("p5_l1", 64'(got_q[1].l), 64'd1);
        end
`endif

        // Backpressure: word pending with m_ready low for 10 cycles.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 1'b0);
        hold = m_data;
        chk("bp_valid", 64'(m_valid), 64'd1);
        s_valid = 1'b1; s_data = 8'h25; s_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_s_ready", 64'(s_ready), 64'd0);
            chk("bp_stable", 64'(m_data), 64'(hold));
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        send_byte(8'h25, 1'b0);
        // Random bytes under random backpressure, checked by the scoreboard.
        rnd_ready = 1'b1;
        for (int i = 0; i < 24; i++) send_byte(8'($urandom), ($urandom_range(0, 4) == 0) || i == 23);
        drain();

        // Back-to-back single-byte packets.
        got_q.delete();
        m_ready = 1'b1;
        send_byte(8'hA0, 1'b1);
        send_byte(8'hA1, 1'b1);
        chk("single_rate", 64'(last_wait), 64'd1);
        send_byte(8'hA2, 1'b1);
        chk("single_rate2", 64'(last_wait), 64'd1);
        drain();
        chk("single_cnt", 64'(got_q.size()), 64'd3);
        foreach (got_q[i]) begin
            chk("single_keep", 64'(got_q[i].k), 64'(W'(1) << ((W - 1) * 0)) << 0 == 0 ? 64'd0 :
`ifdef PACK_MSB_FIRST_EN
                64'(1 << (W - 1))
`else
                64'd1
`endif
            );
            chk("single_last", 64'(got_q[i].l), 64'd1);
        end

        // Reset mid-packet.
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        rst_n = 1'b0;
        #1;
        mcnt = 0; mdata = '0; mkeep = '0; exp_q.delete(); exp_pkt = '0;
        chk("mid_rst_data", 64'(m_data), 64'd0);
        chk("mid_rst_keep", 64'(m_keep), 64'd0);
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_pkt", 64'(pkt_count), 64'd0);
        chk("mid_rst_ready", 64'(s_ready), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        got_q.delete();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        drain();
        chk("post_rst_cnt", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) begin
`ifdef PACK_MSB_FIRST_EN
            chk("post_rst_w", 64'(got_q[0].d), 64'h01020304);
`else
            chk("post_rst_w", 64'(got_q[0].d), 64'h04030201);
`endif
            chk("post_rst_k", 64'(got_q[0].k), 64'hF);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
